// File: rtl/vx_ibuf_pkg.sv
// Shared types and helpers for the multi-queue instruction buffer.
package vx_ibuf_pkg;

   localparam int unsigned MAX_WARPS    = 32;
   localparam int unsigned MAX_WID_BITS = 5;

   // Decoded instruction payload carried from decode to issue
   typedef struct packed {
      logic [7:0]  uuid;
      logic [3:0]  tmask;
      logic [31:0] pc;
      logic [2:0]  ex_type;
      logic [3:0]  op_type;
      logic [2:0]  op_mod;
      logic        wb;
      logic        use_pc;
      logic        use_imm;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rs3;
      logic [2:0]  func3;
      logic [6:0]  func7;
   } ibuf_data_t;

   localparam int unsigned DATAW = $bits(ibuf_data_t);

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_t;

   // First requester strictly after ptr, wrapping modulo n
   function automatic logic [MAX_WID_BITS-1:0] rr_select(
      input logic [MAX_WARPS-1:0]    req,
      input logic [MAX_WID_BITS-1:0] ptr,
      input int unsigned             n
   );
      logic [MAX_WID_BITS-1:0] sel;
      logic                    found;
      int unsigned             idx;
      sel   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_WARPS; i++) begin
         idx = (32'(ptr) + i) % n;
         if (i <= n && !found && req[idx[MAX_WID_BITS-1:0]]) begin
            found = 1'b1;
            sel   = idx[MAX_WID_BITS-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/vx_ibuf_queue.sv
// Single per-warp FIFO with push, pop and whole-queue flush.
module vx_ibuf_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DATAW = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full
);

   localparam int unsigned CNTW = $clog2(DEPTH + 1);
   localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATAW-1:0] mem [DEPTH];
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic [CNTW-1:0]  count;

   // Pointers wrap at DEPTH so non-power-of-two depths work
   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
   endfunction

   // Pointer and occupancy tracking; flush discards everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= data_in;
   end

   assign data_out = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNTW'(DEPTH));

endmodule

// File: rtl/vx_ibuffer_mq.sv
// Multi-queue instruction buffer: one FIFO per warp, round-robin issue
// arbiter with output lock. Optional same-cycle bypass: IBUF_BYPASS_EN.
module vx_ibuffer_mq #(
   parameter  int unsigned NUM_WARPS = 4,
   parameter  int unsigned DEPTH     = 2,
   parameter  int unsigned DATAW     = $bits(vx_ibuf_pkg::ibuf_data_t),
   localparam int unsigned NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [NW_BITS-1:0]   in_wid,
   input  logic [DATAW-1:0]     in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [NW_BITS-1:0]   out_wid,
   output logic [DATAW-1:0]     out_data,
   input  logic                 out_ready,
   input  logic                 flush_valid,
   input  logic [NW_BITS-1:0]   flush_wid,
   output logic [NUM_WARPS-1:0] empty_mask,
   output logic [NUM_WARPS-1:0] full_mask
);

   import vx_ibuf_pkg::*;

   logic [NUM_WARPS-1:0] q_push, q_pop, q_flush, q_empty, q_full;
   logic [DATAW-1:0]     q_head [NUM_WARPS];

   lock_state_t          lock_state, lock_state_nxt;
   logic [NW_BITS-1:0]   lock_wid, lock_wid_nxt;
   logic [NW_BITS-1:0]   rr_ptr, rr_wid, sel_wid;
   logic [DATAW-1:0]     sel_data;
   logic                 cand_valid, bypass, push, pop;

   // Per-warp FIFOs
   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
      vx_ibuf_queue #(
         .DEPTH (DEPTH),
         .DATAW (DATAW)
      ) u_queue (
         .clk      (clk),
         .reset    (reset),
         .push     (q_push[w]),
         .pop      (q_pop[w]),
         .flush    (q_flush[w]),
         .data_in  (in_data),
         .data_out (q_head[w]),
         .empty    (q_empty[w]),
         .full     (q_full[w])
      );
   end

   assign rr_wid = NW_BITS'(rr_select(MAX_WARPS'(~q_empty), MAX_WID_BITS'(rr_ptr), NUM_WARPS));

   // Accept, arbitrate, optional bypass, and per-queue push/pop/flush strobes
   always_comb begin
      in_ready   = !reset && !q_full[in_wid] && !(flush_valid && (flush_wid == in_wid));
      push       = in_valid && in_ready;
      bypass     = 1'b0;
      sel_wid    = rr_wid;
      cand_valid = |(~q_empty);
      if (lock_state == LOCK_HELD) begin
         sel_wid    = lock_wid;
         cand_valid = !q_empty[lock_wid];
      end
      sel_data = q_head[sel_wid];
`ifdef IBUF_BYPASS_EN
      if (&q_empty && (lock_state == LOCK_IDLE) && push) begin
         bypass     = 1'b1;
         sel_wid    = in_wid;
         sel_data   = in_data;
         cand_valid = 1'b1;
      end
`endif
      out_valid = !reset && cand_valid && !(flush_valid && (flush_wid == sel_wid));
      out_wid   = sel_wid;
      out_data  = sel_data;
      pop       = out_valid && out_ready;
      q_push    = '0;
      q_pop     = '0;
      q_flush   = '0;
      if (push && !(bypass && out_ready)) q_push[in_wid]    = 1'b1;
      if (pop && !bypass)                 q_pop[sel_wid]    = 1'b1;
      if (flush_valid)                    q_flush[flush_wid] = 1'b1;
   end

   // Output lock: hold the offered warp until it is taken or flushed
   always_comb begin
      lock_state_nxt = lock_state;
      lock_wid_nxt   = lock_wid;
      case (lock_state)
         LOCK_IDLE: begin
            if (out_valid && !out_ready) begin
               lock_state_nxt = LOCK_HELD;
               lock_wid_nxt   = sel_wid;
            end
         end
         LOCK_HELD: begin
            if (pop || (flush_valid && (flush_wid == lock_wid))) lock_state_nxt = LOCK_IDLE;
         end
         default: lock_state_nxt = LOCK_IDLE;
      endcase
   end

   // Lock state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_state <= LOCK_IDLE;
         lock_wid   <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_wid   <= lock_wid_nxt;
      end
   end

   // Round-robin pointer advances to the popped warp
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= NW_BITS'(NUM_WARPS - 1);
      end else if (pop) begin
         rr_ptr <= sel_wid;
      end
   end

   assign empty_mask = q_empty;
   assign full_mask  = q_full;

endmodule

// File: tb/tb_vx_ibuffer_mq.sv
// Randomized and directed bench for vx_ibuffer_mq against a queue-level model.
module tb_vx_ibuffer_mq;

   localparam int unsigned DATAW = vx_ibuf_pkg::DATAW;
   localparam int          NW    = 4;
   localparam int          DEPTH = 2;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic [1:0]       in_wid;
   logic [DATAW-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [1:0]       out_wid;
   logic [DATAW-1:0] out_data;
   logic             out_ready;
   logic             flush_valid;
   logic [1:0]       flush_wid;
   logic [NW-1:0]    empty_mask;
   logic [NW-1:0]    full_mask;

   vx_ibuffer_mq #(
      .NUM_WARPS (NW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_wid      (in_wid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_wid     (out_wid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .flush_valid (flush_valid),
      .flush_wid   (flush_wid),
      .empty_mask  (empty_mask),
      .full_mask   (full_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: plain queues per warp plus arbitration bookkeeping
   logic [DATAW-1:0] mq [NW][$];
   int               m_last;
   bit               m_locked;
   int               m_lwid;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [DATAW-1:0] rnd_data();
      return DATAW'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   // One cycle: drive, check DUT against model, advance model
   task automatic step(input logic rst, input logic iv, input int iw, input logic [DATAW-1:0] id,
                       input logic ordy, input logic fv, input int fw);
      bit               byp, have, e_ov, e_ir, pop;
      int               cw;
      logic [DATAW-1:0] cd;
      logic [NW-1:0]    e_em, e_fm;
      @(negedge clk);
      reset       = rst;
      in_valid    = iv;
      in_wid      = 2'(iw);
      in_data     = id;
      out_ready   = ordy;
      flush_valid = fv;
      flush_wid   = 2'(fw);
      #1;
      if (rst) begin
         for (int w = 0; w < NW; w++) mq[w].delete();
         m_last   = NW - 1;
         m_locked = 0;
      end
      e_ir = !rst && (mq[iw].size() < DEPTH) && !(fv && fw == iw);
      have = 0;
      byp  = 0;
      cw   = 0;
      cd   = '0;
      if (m_locked) begin
         cw   = m_lwid;
         have = mq[cw].size() > 0;
      end else begin
         for (int k = 1; k <= NW; k++) begin
            if (!have && mq[(m_last + k) % NW].size() > 0) begin
               have = 1;
               cw   = (m_last + k) % NW;
            end
         end
      end
      if (have) cd = mq[cw][0];
`ifdef IBUF_BYPASS_EN
      begin
         bit all_empty;
         all_empty = 1;
         for (int w = 0; w < NW; w++) if (mq[w].size() > 0) all_empty = 0;
         if (all_empty && !m_locked && iv && e_ir) begin
            byp  = 1;
            have = 1;
            cw   = iw;
            cd   = id;
         end
      end
`endif
      e_ov = have && !rst && !(fv && fw == cw);
      for (int w = 0; w < NW; w++) begin
         e_em[w] = (mq[w].size() == 0);
         e_fm[w] = (mq[w].size() == DEPTH);
      end
      chk("in_ready",   128'(in_ready),   128'(e_ir));
      chk("out_valid",  128'(out_valid),  128'(e_ov));
      chk("empty_mask", 128'(empty_mask), 128'(e_em));
      chk("full_mask",  128'(full_mask),  128'(e_fm));
      if (e_ov) begin
         chk("out_wid",  128'(out_wid),  128'(cw));
         chk("out_data", 128'(out_data), 128'(cd));
      end
      if (!rst) begin
         pop = e_ov && ordy;
         if (pop && !byp) void'(mq[cw].pop_front());
         if (pop) m_last = cw;
         if (iv && e_ir && !(byp && ordy)) mq[iw].push_back(id);
         if (fv) mq[fw].delete();
         if (pop) m_locked = 0;
         else if (fv && m_locked && fw == m_lwid) m_locked = 0;
         else if (e_ov && !ordy) begin
            m_locked = 1;
            m_lwid   = cw;
         end
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 0);
   endtask

   task automatic push(input int w, input logic [DATAW-1:0] d, input logic ordy);
      step(1'b0, 1'b1, w, d, ordy, 1'b0, 0);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 0, '0, ordy, 1'b0, 0);
   endtask

   initial begin
      logic [DATAW-1:0] a, b, c, d, x;
      reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_data = '0;
      out_ready = 1'b0; flush_valid = 1'b0; flush_wid = '0;
      m_last = NW - 1; m_locked = 0; m_lwid = 0;
      a = rnd_data(); b = rnd_data(); c = rnd_data(); d = rnd_data(); x = rnd_data();

      // Reset in the middle of traffic
      do_reset();
      push(0, rnd_data(), 1'b0);
      push(1, rnd_data(), 1'b0);
      step(1'b1, 1'b1, 0, rnd_data(), 1'b1, 1'b0, 0);
      chk("t1_out_valid", 128'(out_valid),  128'(0));
      chk("t1_empty",     128'(empty_mask), 128'(4'hF));
      chk("t1_full",      128'(full_mask),  128'(4'h0));
      chk("t1_in_ready",  128'(in_ready),   128'(0));
      idle(1'b0);
      chk("t1_in_ready_rel", 128'(in_ready), 128'(1));

      // Locked output stays stable while other warps fill
      do_reset();
      push(1, a, 1'b0);
      push(1, b, 1'b0);
      push(1, rnd_data(), 1'b0);
      chk("t2_full",      128'(full_mask), 128'(4'b0010));
      chk("t2_ready_w1",  128'(in_ready),  128'(0));
      idle(1'b0);
      chk("t2_ready_w0",  128'(in_ready),  128'(1));
      for (int i = 0; i < 5; i++) begin
         push(0, rnd_data(), 1'b0);
         chk("t2_hold_wid",  128'(out_wid),  128'(1));
         chk("t2_hold_data", 128'(out_data), 128'(a));
      end
      repeat (8) idle(1'b1);

      // Round-robin order
      do_reset();
      push(0, rnd_data(), 1'b0);
      push(2, rnd_data(), 1'b0);
      push(3, rnd_data(), 1'b0);
      idle(1'b1); chk("t3_pop0", 128'(out_wid), 128'(0));
      idle(1'b1); chk("t3_pop2", 128'(out_wid), 128'(2));
      idle(1'b1); chk("t3_pop3", 128'(out_wid), 128'(3));
      push(0, rnd_data(), 1'b0);
      push(3, rnd_data(), 1'b0);
      idle(1'b1); chk("t3_re0", 128'(out_wid), 128'(0));
      idle(1'b1); chk("t3_re3", 128'(out_wid), 128'(3));

      // Push and pop on the same warp; full warp refuses push even when popping
      do_reset();
      push(2, b, 1'b0);
      push(2, c, 1'b1);
      chk("t4_ready_pp", 128'(in_ready), 128'(1));
      chk("t4_first",    128'(out_data), 128'(b));
      idle(1'b1);
      chk("t4_next_c",   128'(out_data), 128'(c));
      push(2, a, 1'b0);
      push(2, x, 1'b0);
      push(2, d, 1'b1);
      chk("t4_full",     128'(full_mask), 128'(4'b0100));
      chk("t4_refuse",   128'(in_ready),  128'(0));
      idle(1'b1);
      chk("t4_second",   128'(out_data),  128'(x));
      idle(1'b1);
      chk("t4_drained",  128'(empty_mask), 128'(4'hF));

      // Flush of the locked warp withdraws the output and drops a same-cycle push
      do_reset();
      push(2, a, 1'b0);
      push(2, b, 1'b0);
      push(0, c, 1'b0);
      step(1'b0, 1'b1, 2, d, 1'b1, 1'b1, 2);
      chk("t5_ov_drop", 128'(out_valid), 128'(0));
      chk("t5_refuse",  128'(in_ready),  128'(0));
      idle(1'b0);
      chk("t5_empty",   128'(empty_mask), 128'(4'b1110));
      chk("t5_ov",      128'(out_valid),  128'(1));
      chk("t5_wid",     128'(out_wid),    128'(0));
      chk("t5_data",    128'(out_data),   128'(c));
      repeat (4) idle(1'b1);

      // Minimum latency from an all-empty buffer
      do_reset();
      push(3, x, 1'b1);
`ifdef IBUF_BYPASS_EN
      chk("t6_byp_ov",   128'(out_valid), 128'(1));
      chk("t6_byp_data", 128'(out_data),  128'(x));
      idle(1'b1);
      chk("t6_byp_empty", 128'(empty_mask), 128'(4'hF));
      chk("t6_byp_none",  128'(out_valid),  128'(0));
`else
      chk("t6_ov0", 128'(out_valid), 128'(0));
      idle(1'b1);
      chk("t6_ov1",  128'(out_valid), 128'(1));
      chk("t6_data", 128'(out_data),  128'(x));
`endif

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 9) < 6),
              int'($urandom_range(0, NW - 1)),
              rnd_data(),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, NW - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
